// File: rtl/msrv32_machine_control.sv
// ----------------------------------------------------------------------------
// msrv32_machine_control
//
// Machine-mode trap controller for the msrv32 core. Watches the decoder's
// exception flags, the SYSTEM instruction fields (ECALL / EBREAK / MRET) and
// the enabled/pending machine interrupts, and sequences reset, trap entry and
// trap return with a four-state Moore FSM.
//
// Ports
//   clk_in, rst_in            clock; synchronous active-low reset
//   illegal_instr_in          decoder: illegal instruction
//   misaligned_load_in        decoder: misaligned load address
//   misaligned_store_in       decoder: misaligned store address
//   misaligned_instr_in       target PC not word aligned
//   opcode_6_to_2_in, funct3_in, funct7_in,
//   rs1_addr_in, rs2_addr_in, rd_addr_in
//                             instruction fields for SYSTEM decode
//   mie_in                    mstatus.MIE (global interrupt enable)
//   meie_in/mtie_in/msie_in   mie.MEIE/MTIE/MSIE
//   meip_in/mtip_in/msip_in   mip.MEIP/MTIP/MSIP
//   pc_src_out                00 boot, 01 mepc, 10 trap vector, 11 next PC
//   flush_out                 kill the instruction in flight
//   trap_taken_out            to decoder trap_taken_in
//   i_or_e_out, cause_out     mcause[31] and mcause[3:0]
//   set_cause_out             write mcause
//   set_epc_out               write mepc with current PC
//   mie_clear_out             MPIE <= MIE, MIE <= 0
//   mie_set_out               MIE <= MPIE
//   instret_inc_out           minstret increment
//
// Handshake: there is no valid/ready flow here. Every strobe output is a
// single-cycle pulse asserted for exactly the one cycle the FSM spends in the
// corresponding state; consumers act on it at the next rising edge.
// ----------------------------------------------------------------------------
module msrv32_machine_control (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       illegal_instr_in,
   input  logic       misaligned_load_in,
   input  logic       misaligned_store_in,
   input  logic       misaligned_instr_in,
   input  logic [4:0] opcode_6_to_2_in,
   input  logic [2:0] funct3_in,
   input  logic [6:0] funct7_in,
   input  logic [4:0] rs1_addr_in,
   input  logic [4:0] rs2_addr_in,
   input  logic [4:0] rd_addr_in,
   input  logic       mie_in,
   input  logic       meie_in,
   input  logic       mtie_in,
   input  logic       msie_in,
   input  logic       meip_in,
   input  logic       mtip_in,
   input  logic       msip_in,
   output logic [1:0] pc_src_out,
   output logic       flush_out,
   output logic       trap_taken_out,
   output logic       i_or_e_out,
   output logic [3:0] cause_out,
   output logic       set_cause_out,
   output logic       set_epc_out,
   output logic       mie_clear_out,
   output logic       mie_set_out,
   output logic       instret_inc_out
);

   typedef enum logic [1:0] {
      RESET       = 2'b00,
      OPERATING   = 2'b01,
      TRAP_TAKEN  = 2'b10,
      TRAP_RETURN = 2'b11
   } state_t;

   // Current state is kept in a plainly named signal so checkers can bind to it.
   state_t state;
   state_t next_state;

   logic       sys;
   logic       ecall;
   logic       ebreak;
   logic       mret;
   logic       mei;
   logic       msi;
   logic       mti;
   logic       irq;
   logic       exc;
   logic       trap_req;
   logic       next_i_or_e;
   logic [3:0] next_cause;

   // SYSTEM / PRIV encodings. WFI and other funct3=000 forms fall through
   // every decode below and behave as a NOP.
   assign sys    = (opcode_6_to_2_in == 5'b11100) && (funct3_in == 3'b000) &&
                   (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
   assign ecall  = sys && (funct7_in == 7'b0000000) && (rs2_addr_in == 5'd0);
   assign ebreak = sys && (funct7_in == 7'b0000000) && (rs2_addr_in == 5'd1);
   assign mret   = sys && (funct7_in == 7'b0011000) && (rs2_addr_in == 5'd2);

   // Interrupt sources already qualified by their enables and global MIE.
   assign mei = mie_in & meie_in & meip_in;
   assign msi = mie_in & msie_in & msip_in;
   assign mti = mie_in & mtie_in & mtip_in;
   assign irq = mei | msi | mti;

   assign exc = illegal_instr_in | misaligned_instr_in | misaligned_load_in |
                misaligned_store_in | ecall | ebreak;

   assign trap_req = irq | exc;

   // Cause selection: interrupts first, then exceptions in fixed priority.
   always_comb begin
      next_i_or_e = 1'b0;
      next_cause  = 4'd0;
      if (mei) begin
         next_i_or_e = 1'b1;
         next_cause  = 4'd11;
      end else if (msi) begin
         next_i_or_e = 1'b1;
         next_cause  = 4'd3;
      end else if (mti) begin
         next_i_or_e = 1'b1;
         next_cause  = 4'd7;
      end else if (misaligned_instr_in) begin
         next_cause  = 4'd0;
      end else if (illegal_instr_in) begin
         next_cause  = 4'd2;
      end else if (ebreak) begin
         next_cause  = 4'd3;
      end else if (ecall) begin
         next_cause  = 4'd11;
      end else if (misaligned_load_in) begin
         next_cause  = 4'd4;
      end else if (misaligned_store_in) begin
         next_cause  = 4'd6;
      end
   end

   // Next-state logic. Inputs only matter while OPERATING; a trap request
   // always beats a simultaneous MRET.
   always_comb begin
      next_state = state;
      case (state)
         RESET:       next_state = OPERATING;
         OPERATING: begin
            if (trap_req) begin
               next_state = TRAP_TAKEN;
            end else if (mret) begin
               next_state = TRAP_RETURN;
            end
         end
         TRAP_TAKEN:  next_state = OPERATING;
         TRAP_RETURN: next_state = OPERATING;
         default:     next_state = RESET;
      endcase
   end

   // State and mcause register. Cause is captured only on trap entry.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state      <= RESET;
         i_or_e_out <= 1'b0;
         cause_out  <= 4'd0;
      end else begin
         state <= next_state;
         if ((state == OPERATING) && trap_req) begin
            i_or_e_out <= next_i_or_e;
            cause_out  <= next_cause;
         end
      end
   end

   // Moore outputs; instret_inc additionally needs the current trap request
   // so that a trapping instruction is not counted as retired.
   always_comb begin
      pc_src_out      = 2'b11;
      flush_out       = 1'b0;
      trap_taken_out  = 1'b0;
      set_cause_out   = 1'b0;
      set_epc_out     = 1'b0;
      mie_clear_out   = 1'b0;
      mie_set_out     = 1'b0;
      instret_inc_out = 1'b0;
      case (state)
         RESET: begin
            pc_src_out = 2'b00;
            flush_out  = 1'b1;
         end
         OPERATING: begin
            pc_src_out      = 2'b11;
            instret_inc_out = ~trap_req;
         end
         TRAP_TAKEN: begin
            pc_src_out     = 2'b10;
            flush_out      = 1'b1;
            trap_taken_out = 1'b1;
            set_cause_out  = 1'b1;
            set_epc_out    = 1'b1;
            mie_clear_out  = 1'b1;
         end
         TRAP_RETURN: begin
            pc_src_out  = 2'b01;
            flush_out   = 1'b1;
            mie_set_out = 1'b1;
         end
         default: begin
            pc_src_out = 2'b00;
            flush_out  = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_msrv32_machine_control.sv
// ----------------------------------------------------------------------------
// tb_msrv32_machine_control
//
// Bench for msrv32_machine_control: a reset sequence, a table of directed
// single-instruction vectors, hand-written multi-cycle corner cases, and a
// randomized run checked against a rule-level reference model.
// ----------------------------------------------------------------------------
module tb_msrv32_machine_control;

   // ---------------- clock / reset ----------------
   logic       clk;
   logic       rst;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic       illegal, mis_l, mis_s, mis_i;
   logic [4:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [4:0] rs1, rs2, rd;
   logic       mie, meie, mtie, msie, meip, mtip, msip;
   logic [1:0] pc_src;
   logic       flush, trap_taken, i_or_e, set_cause, set_epc;
   logic       mie_clear, mie_set, instret_inc;
   logic [3:0] cause;

   msrv32_machine_control dut (
      .clk_in              (clk),
      .rst_in              (rst),
      .illegal_instr_in    (illegal),
      .misaligned_load_in  (mis_l),
      .misaligned_store_in (mis_s),
      .misaligned_instr_in (mis_i),
      .opcode_6_to_2_in    (opcode),
      .funct3_in           (funct3),
      .funct7_in           (funct7),
      .rs1_addr_in         (rs1),
      .rs2_addr_in         (rs2),
      .rd_addr_in          (rd),
      .mie_in              (mie),
      .meie_in             (meie),
      .mtie_in             (mtie),
      .msie_in             (msie),
      .meip_in             (meip),
      .mtip_in             (mtip),
      .msip_in             (msip),
      .pc_src_out          (pc_src),
      .flush_out           (flush),
      .trap_taken_out      (trap_taken),
      .i_or_e_out          (i_or_e),
      .cause_out           (cause),
      .set_cause_out       (set_cause),
      .set_epc_out         (set_epc),
      .mie_clear_out       (mie_clear),
      .mie_set_out         (mie_set),
      .instret_inc_out     (instret_inc)
   );

   // ---------------- scoreboard counters ----------------
   int errors = 0;
   int checks = 0;

   // Model modes are named by the pc_src value the controller shows in them.
   localparam logic [1:0] M_RST = 2'b00;
   localparam logic [1:0] M_RET = 2'b01;
   localparam logic [1:0] M_TRP = 2'b10;
   localparam logic [1:0] M_OP  = 2'b11;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Everything except cause/instret follows from which mode we are in.
   task automatic chk_mode(input string tag, input logic [1:0] m);
      chk({tag, " pc_src"},     {30'd0, pc_src},     {30'd0, m});
      chk({tag, " flush"},      {31'd0, flush},      {31'd0, m != M_OP});
      chk({tag, " trap_taken"}, {31'd0, trap_taken}, {31'd0, m == M_TRP});
      chk({tag, " set_cause"},  {31'd0, set_cause},  {31'd0, m == M_TRP});
      chk({tag, " set_epc"},    {31'd0, set_epc},    {31'd0, m == M_TRP});
      chk({tag, " mie_clear"},  {31'd0, mie_clear},  {31'd0, m == M_TRP});
      chk({tag, " mie_set"},    {31'd0, mie_set},    {31'd0, m == M_RET});
   endtask

   task automatic chk_cause(input string tag, input logic ioe, input logic [3:0] c);
      chk({tag, " i_or_e"}, {31'd0, i_or_e}, {31'd0, ioe});
      chk({tag, " cause"},  {28'd0, cause},  {28'd0, c});
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_inputs();
      illegal = 0; mis_l = 0; mis_s = 0; mis_i = 0;
      opcode = 5'b01100; funct3 = 0; funct7 = 0; rs1 = 0; rs2 = 0; rd = 0;
      mie = 0; meie = 0; mtie = 0; msie = 0; meip = 0; mtip = 0; msip = 0;
   endtask

   typedef struct {
      logic [3:0] exc;   // {mis_i, illegal, mis_l, mis_s}
      logic [4:0] opcode;
      logic [6:0] funct7;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       mie;
      logic [2:0] en;    // {meie, msie, mtie}
      logic [2:0] ip;    // {meip, msip, mtip}
      logic [1:0] exp_mode;
      logic       exp_ioe;
      logic [3:0] exp_cause;
      logic       exp_inc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [3:0] e, logic [4:0] op, logic [6:0] f7, logic [4:0] r1,
                               logic [4:0] r2, logic m, logic [2:0] en, logic [2:0] ip,
                               logic [1:0] xm, logic xioe, logic [3:0] xc, logic xinc);
      vec_t v;
      v.exc = e; v.opcode = op; v.funct7 = f7; v.rs1 = r1; v.rs2 = r2;
      v.mie = m; v.en = en; v.ip = ip;
      v.exp_mode = xm; v.exp_ioe = xioe; v.exp_cause = xc; v.exp_inc = xinc;
      return v;
   endfunction

   task automatic apply_vec(input vec_t v);
      {mis_i, illegal, mis_l, mis_s} = v.exc;
      opcode = v.opcode; funct3 = 3'b000; funct7 = v.funct7;
      rs1 = v.rs1; rs2 = v.rs2; rd = 5'd0;
      mie = v.mie; {meie, msie, mtie} = v.en; {meip, msip, mtip} = v.ip;
   endtask

   // ---------------- reference model ----------------
   // Evaluates the architectural trap rules on the currently driven inputs:
   // walks an ordered priority list and reports the first matching cause.
   function automatic void model_eval(output logic trap, output logic ioe,
                                      output logic [3:0] c, output logic is_mret);
      logic       is_sys;
      logic       cond [9];
      logic       ie   [9];
      logic [3:0] code [9];
      is_sys  = (opcode == 5'b11100) && (funct3 == 0) && (rs1 == 0) && (rd == 0);
      is_mret = is_sys && funct7 == 7'h18 && rs2 == 5'd2;
      cond[0] = mie && meie && meip; ie[0] = 1; code[0] = 11;
      cond[1] = mie && msie && msip; ie[1] = 1; code[1] = 3;
      cond[2] = mie && mtie && mtip; ie[2] = 1; code[2] = 7;
      cond[3] = mis_i;                ie[3] = 0; code[3] = 0;
      cond[4] = illegal;              ie[4] = 0; code[4] = 2;
      cond[5] = is_sys && funct7 == 0 && rs2 == 1; ie[5] = 0; code[5] = 3;
      cond[6] = is_sys && funct7 == 0 && rs2 == 0; ie[6] = 0; code[6] = 11;
      cond[7] = mis_l;                ie[7] = 0; code[7] = 4;
      cond[8] = mis_s;                ie[8] = 0; code[8] = 6;
      trap = 0; ioe = 0; c = 0;
      for (int i = 8; i >= 0; i--) begin
         if (cond[i]) begin
            trap = 1; ioe = ie[i]; c = code[i];
         end
      end
   endfunction

   // ---------------- test ----------------
   initial begin
      logic [1:0] m_mode;
      logic       m_ioe;
      logic [3:0] m_cause;
      logic       t_trap, t_ioe, t_mret;
      logic [3:0] t_cause;

      clear_inputs();
      rst = 0;

      // Reset: held low three cycles, then released.
      tick(); tick(); tick();
      chk_mode("reset_low", M_RST);
      chk_cause("reset_low", 0, 0);
      chk("reset_low instret", {31'd0, instret_inc}, 0);
      rst = 1;
      #1;
      chk_mode("reset_release", M_RST);
      tick();
      #1;
      chk_mode("first_op", M_OP);
      chk("first_op instret", {31'd0, instret_inc}, 1);

      // Directed table: {exc, opcode, funct7, rs1, rs2, mie, en, ip, mode, ioe, cause, inc}
      vecs.push_back(mk(4'b0110, 5'b01100, 7'h00, 0, 0, 0, 3'b000, 3'b000, M_TRP, 0, 2,  0));
      vecs.push_back(mk(4'b0000, 5'b11100, 7'h00, 0, 0, 1, 3'b011, 3'b011, M_TRP, 1, 3,  0));
      vecs.push_back(mk(4'b0000, 5'b11100, 7'h00, 0, 0, 0, 3'b011, 3'b011, M_TRP, 0, 11, 0));
      vecs.push_back(mk(4'b0000, 5'b11100, 7'h18, 0, 2, 0, 3'b000, 3'b000, M_RET, 0, 11, 1));
      vecs.push_back(mk(4'b0000, 5'b11100, 7'h18, 0, 2, 1, 3'b100, 3'b100, M_TRP, 1, 11, 0));
      vecs.push_back(mk(4'b0000, 5'b11100, 7'h00, 0, 1, 0, 3'b000, 3'b000, M_TRP, 0, 3,  0));
      vecs.push_back(mk(4'b0000, 5'b11100, 7'h08, 0, 5, 0, 3'b000, 3'b000, M_OP,  0, 3,  1));
      vecs.push_back(mk(4'b1100, 5'b11100, 7'h00, 0, 0, 0, 3'b000, 3'b000, M_TRP, 0, 0,  0));
      vecs.push_back(mk(4'b0001, 5'b01100, 7'h00, 0, 0, 0, 3'b000, 3'b000, M_TRP, 0, 6,  0));
      vecs.push_back(mk(4'b0011, 5'b01100, 7'h00, 0, 0, 0, 3'b000, 3'b000, M_TRP, 0, 4,  0));
      vecs.push_back(mk(4'b0000, 5'b01100, 7'h00, 0, 0, 1, 3'b111, 3'b111, M_TRP, 1, 11, 0));
      vecs.push_back(mk(4'b0000, 5'b01100, 7'h00, 0, 0, 1, 3'b111, 3'b001, M_TRP, 1, 7,  0));
      vecs.push_back(mk(4'b0000, 5'b11100, 7'h00, 3, 0, 0, 3'b000, 3'b000, M_OP,  1, 7,  1));
      vecs.push_back(mk(4'b0000, 5'b01100, 7'h00, 0, 0, 1, 3'b011, 3'b100, M_OP,  1, 7,  1));
      vecs.push_back(mk(4'b0010, 5'b01100, 7'h00, 0, 0, 1, 3'b010, 3'b010, M_TRP, 1, 3,  0));

      foreach (vecs[i]) begin
         apply_vec(vecs[i]);
         #1;
         chk($sformatf("vec%0d instret", i), {31'd0, instret_inc}, {31'd0, vecs[i].exp_inc});
         tick();
         clear_inputs();
         #1;
         chk_mode($sformatf("vec%0d", i), vecs[i].exp_mode);
         chk_cause($sformatf("vec%0d", i), vecs[i].exp_ioe, vecs[i].exp_cause);
         tick();
         #1;
         chk_mode($sformatf("vec%0d after", i), M_OP);
      end

      // Inputs changing during TRAP_TAKEN are ignored; the following
      // OPERATING cycle is mandatory before the next trap.
      illegal = 1;
      tick();
      illegal = 0; opcode = 5'b11100;   // ecall presented while in TRAP_TAKEN
      #1;
      chk_mode("b2b first", M_TRP);
      chk_cause("b2b first", 0, 2);
      tick();
      #1;
      chk_mode("b2b gap", M_OP);
      chk_cause("b2b gap", 0, 2);
      chk("b2b gap instret", {31'd0, instret_inc}, 0);
      tick();
      clear_inputs();
      #1;
      chk_mode("b2b second", M_TRP);
      chk_cause("b2b second", 0, 11);
      tick();

      // Reset dropped in the middle of a trap.
      mis_s = 1;
      tick();
      clear_inputs();
      #1;
      chk_mode("mid_trap", M_TRP);
      chk_cause("mid_trap", 0, 6);
      rst = 0;
      tick();
      #1;
      chk_mode("mid_trap reset", M_RST);
      chk_cause("mid_trap reset", 0, 0);
      rst = 1;
      tick();
      #1;
      chk_mode("mid_trap recover", M_OP);

      // Randomized run against the reference model.
      m_mode = M_OP; m_ioe = 0; m_cause = 0;
      for (int n = 0; n < 2000; n++) begin
         rst     = ($urandom_range(0, 39) != 0);
         illegal = ($urandom_range(0, 7) == 0);
         mis_l   = ($urandom_range(0, 7) == 0);
         mis_s   = ($urandom_range(0, 7) == 0);
         mis_i   = ($urandom_range(0, 11) == 0);
         opcode  = ($urandom_range(0, 1) == 0) ? 5'b11100 : 5'($urandom_range(0, 31));
         funct3  = ($urandom_range(0, 3) != 0) ? 3'b000 : 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0:       funct7 = 7'h00;
            1:       funct7 = 7'h18;
            2:       funct7 = 7'h08;
            default: funct7 = 7'($urandom_range(0, 127));
         endcase
         case ($urandom_range(0, 3))
            0:       rs2 = 5'd0;
            1:       rs2 = 5'd1;
            2:       rs2 = 5'd2;
            default: rs2 = 5'd5;
         endcase
         rs1  = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
         rd   = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
         mie  = 1'($urandom_range(0, 1));
         meie = 1'($urandom_range(0, 1)); meip = ($urandom_range(0, 3) == 0);
         msie = 1'($urandom_range(0, 1)); msip = ($urandom_range(0, 3) == 0);
         mtie = 1'($urandom_range(0, 1)); mtip = ($urandom_range(0, 3) == 0);
         #1;
         model_eval(t_trap, t_ioe, t_cause, t_mret);
         chk_mode($sformatf("rnd%0d", n), m_mode);
         chk_cause($sformatf("rnd%0d", n), m_ioe, m_cause);
         chk($sformatf("rnd%0d instret", n), {31'd0, instret_inc},
             {31'd0, (m_mode == M_OP) && !t_trap});
         if (!rst) begin
            m_mode = M_RST; m_ioe = 0; m_cause = 0;
         end else if (m_mode != M_OP) begin
            m_mode = M_OP;
         end else if (t_trap) begin
            m_mode = M_TRP; m_ioe = t_ioe; m_cause = t_cause;
         end else if (t_mret) begin
            m_mode = M_RET;
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
